// File: rtl/mips_control_fsm.sv
// mips_control_fsm: multicycle MIPS main control unit (Moore FSM).
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   op[5:0]           - opcode from the instruction register
//   zero              - ALU zero flag (only used for branch PC enable)
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca
//                     - datapath selects and write strobes
//   alusrcb[1:0], aluop[1:0], pcsrc[1:0] - datapath selects
//   pcen              - PC load enable (combinational in zero)
//   state[3:0]        - current state code for debug
module mips_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_pcwrite;
    logic       w_branch;

    // State register; reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; op is only consulted in DECODE and MEMADR
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:   w_next_state = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) w_next_state = S_MEMADR;
                else if (op == OP_RTYPE)        w_next_state = S_EXECUTE;
                else if (op == OP_BEQ)          w_next_state = S_BRANCH;
                else if (op == OP_ADDI)         w_next_state = S_ADDIEX;
                else if (op == OP_J)            w_next_state = S_JUMP;
                else                            w_next_state = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_LW)      w_next_state = S_MEMRD;
                else if (op == OP_SW) w_next_state = S_MEMWR;
                else                  w_next_state = S_FETCH;
            end
            S_MEMRD:   w_next_state = S_MEMWB;
            S_EXECUTE: w_next_state = S_ALUWB;
            S_ADDIEX:  w_next_state = S_ADDIWB;
            default:   w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode; unused codes fall through to all-zero
    always_comb begin
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        pcsrc     = 2'b00;
        w_pcwrite = 1'b0;
        w_branch  = 1'b0;
        case (r_state)
            S_FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b01;
                w_pcwrite = 1'b1;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
            end
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsrc    = 2'b01;
                w_branch = 1'b1;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Branch resolves in the same cycle the ALU reports zero
    assign pcen  = w_pcwrite | (w_branch & zero);
    assign state = r_state;

endmodule

// File: tb/tb_mips_control_fsm.sv
// tb_mips_control_fsm: scoreboard bench for the multicycle control FSM.
module tb_mips_control_fsm;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] outs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;
    logic [13:0] w_outs;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mips_control_fsm dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen),
        .state(state)
    );

    always #5 clk = ~clk;

    assign w_outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                     alusrcb, aluop, pcsrc, pcen};

    // Reference output table for a given state and zero flag
    function automatic logic [13:0] exp_outs(input logic [3:0] st, input logic z);
        logic io, mw, ir, rd, mr, rw, sa, pw, br;
        logic [1:0] sb, ao, ps;
        {io, mw, ir, rd, mr, rw, sa, pw, br} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin ir = 1; sb = 2'b01; pw = 1; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  io = 1;
            4'd4:  begin mr = 1; rw = 1; end
            4'd5:  begin io = 1; mw = 1; end
            4'd6:  begin sa = 1; ao = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            4'd9:  begin sa = 1; sb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        return {io, mw, ir, rd, mr, rw, sa, sb, ao, ps, pw | (br & z)};
    endfunction

    // One cycle: drive op/zero, expect state es, compare after settling
    task automatic step(input string nm, input logic [5:0] o, input logic z, input logic [3:0] es);
        exp_t e;
        @(negedge clk);
        op = o;
        zero = z;
        exp_q.push_back('{st: es, outs: exp_outs(es, z)});
        #1;
        e = exp_q.pop_front();
        checks++;
        if (state !== e.st) begin
            errors++;
            $display("FAIL %s state: got %0d expected %0d", nm, state, e.st);
        end
        checks++;
        if (w_outs !== e.outs) begin
            errors++;
            $display("FAIL %s outputs(state %0d): got %b expected %b", nm, e.st, w_outs, e.outs);
        end
        checks++;
        if (regwrite && memwrite) begin
            errors++;
            $display("FAIL %s exclusive strobes: regwrite=%b memwrite=%b expected not both", nm, regwrite, memwrite);
        end
    endtask

    task automatic check_fetch_now(input string nm);
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL %s state: got %0d expected 0", nm, state);
        end
        checks++;
        if (w_outs !== exp_outs(4'd0, zero)) begin
            errors++;
            $display("FAIL %s outputs: got %b expected %b", nm, w_outs, exp_outs(4'd0, zero));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = 6'b000000;
        zero = 1'b0;
        #3;
        check_fetch_now("reset_async");
        @(posedge clk);
        #1;
        check_fetch_now("reset_held");
        reset = 1'b0;
    endtask

    task automatic test_lw();
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        foreach (seq[i]) step("lw", 6'b100011, 1'b0, seq[i]);
    endtask

    task automatic test_sw();
        logic [3:0] seq [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
        foreach (seq[i]) step("sw", 6'b101011, 1'b0, seq[i]);
    endtask

    task automatic test_beq();
        step("beq_taken", 6'b000100, 1'b0, 4'd0);
        step("beq_taken", 6'b000100, 1'b0, 4'd1);
        step("beq_taken", 6'b000100, 1'b1, 4'd8);
        step("beq_not",   6'b000100, 1'b0, 4'd0);
        step("beq_not",   6'b000100, 1'b0, 4'd1);
        step("beq_not",   6'b000100, 1'b0, 4'd8);
    endtask

    task automatic test_illegal();
        step("illegal", 6'b111111, 1'b0, 4'd0);
        step("illegal", 6'b111111, 1'b0, 4'd1);
        step("illegal_ret", 6'b111111, 1'b0, 4'd0);
        step("illegal_ret", 6'b111111, 1'b0, 4'd1);
    endtask

    // Opcode changes outside DECODE/MEMADR must not alter the path
    task automatic test_op_hold();
        step("op_hold", 6'b000000, 1'b0, 4'd0);
        step("op_hold", 6'b000000, 1'b0, 4'd1);
        step("op_hold", 6'b100011, 1'b0, 4'd6);
        step("op_hold", 6'b000010, 1'b0, 4'd7);
        step("lw_hold", 6'b100011, 1'b0, 4'd0);
        step("lw_hold", 6'b100011, 1'b0, 4'd1);
        step("lw_hold", 6'b100011, 1'b0, 4'd2);
        step("lw_hold", 6'b101011, 1'b0, 4'd3);
        step("lw_hold", 6'b000010, 1'b0, 4'd4);
    endtask

    task automatic test_reset_mid();
        step("mid_rst", 6'b100011, 1'b0, 4'd0);
        step("mid_rst", 6'b100011, 1'b0, 4'd1);
        step("mid_rst", 6'b100011, 1'b0, 4'd2);
        step("mid_rst", 6'b100011, 1'b0, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        check_fetch_now("mid_rst_immediate");
        @(posedge clk);
        #1;
        check_fetch_now("mid_rst_held");
        reset = 1'b0;
        step("post_rst", 6'b000000, 1'b0, 4'd0);
        step("post_rst", 6'b000000, 1'b0, 4'd1);
        step("post_rst", 6'b000000, 1'b0, 4'd6);
        step("post_rst", 6'b000000, 1'b0, 4'd7);
    endtask

    task automatic test_back_to_back();
        step("addi", 6'b001000, 1'b0, 4'd0);
        step("addi", 6'b001000, 1'b0, 4'd1);
        step("addi", 6'b001000, 1'b0, 4'd9);
        step("addi", 6'b001000, 1'b0, 4'd10);
        step("j",    6'b000010, 1'b0, 4'd0);
        step("j",    6'b000010, 1'b0, 4'd1);
        step("j",    6'b000010, 1'b0, 4'd11);
        step("j_end", 6'b000000, 1'b0, 4'd0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_beq();
        test_illegal();
        test_op_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
 OP_RTYPE, 6'b000000, R-type opcode
 OP_LW, 6'b100011, load word
 OP_SW, 6'b101011, store word
 OP_BEQ, 6'b000100, branch-if-equal
 OP_ADDI, 6'b001000, add immediate
 OP_J, 6'b000010, jump
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
 clk  in  1  single clock, all state updates on rising edge
 reset  in  1  asynchronous, active-high
 op  in  6  opcode of current instruction register
 zero  in  1  ALU zero flag
 iord  out  1  memory address select (0 = PC, 1 = ALUOut)
 memwrite  out  1  data memory write enable
 irwrite  out  1  instruction register load enable
 regdst  out  1  destination select (0 = rt, 1 = rd)
 memtoreg  out  1  write-back select (0 = ALUOut, 1 = memory data)
 regwrite  out  1  register file write enable
 alusrca  out  1  ALU A select (0 = PC, 1 = register A)
 alusrcb  out  2  ALU B select (00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2)
 aluop  out  2  to ALU decoder (00 = add, 01 = subtract, 10 = use funct)
 pcsrc  out  2  next PC select (00 = ALU result, 01 = ALUOut, 10 = jump target)
 pcen  out  1  PC register load enable
 state  out  4  current state code, for debug/verification

Function
REQ-003 The block SHALL be a Moore FSM with 4-bit state register; codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-004 Transitions SHALL be: FETCH->DECODE; DECODE->MEMADR (LW/SW), EXECUTE (RTYPE), BRANCH (BEQ), ADDIEX (ADDI), JUMP (J); MEMADR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-005 An op not matching any parameter in DECODE SHALL return to FETCH (instruction treated as NOP, no write asserted).
REQ-006 op SHALL be sampled in DECODE and MEMADR only; op changes in other states SHALL NOT affect transitions.
REQ-007 Outputs SHALL be decoded from state only (except pcen); any signal not listed for a state SHALL be 0:
 FETCH: irwrite=1, alusrcb=01, aluop=00, pcsrc=00, pcwrite=1
 DECODE: alusrcb=11, aluop=00
 MEMADR / ADDIEX: alusrca=1, alusrcb=10, aluop=00
 MEMRD: iord=1
 MEMWB: memtoreg=1, regwrite=1
 MEMWR: iord=1, memwrite=1
 EXECUTE: alusrca=1, alusrcb=00, aluop=10
 ALUWB: regdst=1, regwrite=1
 BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1
 ADDIWB: regwrite=1 (regdst=0, memtoreg=0)
 JUMP: pcsrc=10, pcwrite=1
REQ-008 pcen SHALL equal pcwrite OR (branch AND zero), combinational, same cycle as zero.
REQ-009 Instruction latency SHALL be: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal 2 cycles (FETCH to next FETCH).
REQ-010 Unused state codes 12-15 SHALL drive all outputs 0 and go to FETCH on the next edge.
REQ-011 At most one of regwrite, memwrite SHALL be 1 in any cycle; irwrite SHALL be 1 only in FETCH.

Reset
REQ-012 reset=1 SHALL force state to FETCH immediately, independent of clk, aborting any instruction mid-sequence with no further write strobes.
REQ-013 During reset, outputs SHALL show FETCH values; first edge after deassert SHALL move to DECODE.

Verification
REQ-014 Bench SHALL cover:
 LW (op=100011): state 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
 SW (op=101011): state 0,1,2,5,0; memwrite=1, iord=1 only in state 5.
 BEQ with zero=1 in state 8 -> pcen=1, pcsrc=01; repeat with zero=0 -> pcen=0.
 op=111111 in DECODE -> back to FETCH next edge, no regwrite/memwrite.
 reset asserted mid-clock in MEMRD -> state=0 immediately, then DECODE after release.
 ADDI then J back-to-back: states 0,1,9,10,0,1,11,0; pcsrc=10 and pcen=1 in state 11.
